// File: rtl/rtc_bus_scheduler.sv
// RTC bus scheduler: time-shares the bus timing generator between a one-entry
// buffered user write and periodic read bursts of the RTC time registers.
module rtc_bus_scheduler #(
  parameter logic [7:0]  READ_BASE = 8'h21,
  parameter int unsigned N_READ    = 6,
  parameter int unsigned GAP       = 2,
  parameter int unsigned TIMEOUT   = 100
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       refresh_tick,
  input  logic       wr_req,
  input  logic [7:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       wr_ack,
  input  logic       gen_dir,
  input  logic       gen_dat,
  input  logic       gen_dat_lect,
  input  logic       gen_done,
  output logic       en_esc,
  output logic       en_lect,
  output logic [7:0] bus_out,
  input  logic [7:0] rd_bus_in,
  output logic       rd_valid,
  output logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       burst_done,
  output logic       err
);

  localparam int unsigned IDX_W = (N_READ > 1) ? $clog2(N_READ) : 1;
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
  localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WR_RUN, S_RD_RUN, S_GAP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               full_q, full_d;
  logic               abort_q, abort_d;
  logic               pend_q, pend_d;
  logic [7:0]         waddr_q, waddr_d, wdata_q, wdata_d;
  logic [7:0]         samp_q, samp_d;
  logic               wr_ready_q, wr_ready_d, wr_ack_q, wr_ack_d;
  logic               en_esc_q, en_esc_d, en_lect_q, en_lect_d;
  logic [7:0]         bus_out_q, bus_out_d;
  logic               rd_valid_q, rd_valid_d, burst_done_q, burst_done_d;
  logic [7:0]         rd_addr_q, rd_addr_d, rd_data_q, rd_data_d;
  logic               busy_q, busy_d, err_q, err_d;

  logic run, done_evt, tmo_evt;

  assign run      = (state_q == S_WR_RUN) || (state_q == S_RD_RUN);
  assign done_evt = run && gen_done;
  // done wins over a timeout landing in the same cycle
  assign tmo_evt  = run && !gen_done && (cnt_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state; arbitration only in IDLE, write before burst
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (full_q)                            state_d = S_WR_RUN;
        else if ((idx_q != '0) || pend_q)      state_d = S_RD_RUN;
      end
      S_WR_RUN, S_RD_RUN: begin
        if (done_evt || tmo_evt)               state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == GAP_W'(GAP - 1))          state_d = S_IDLE;
      end
      default:                                 state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    cnt_d        = '0;
    gap_d        = '0;
    idx_d        = idx_q;
    full_d       = full_q;
    abort_d      = abort_q;
    pend_d       = pend_q;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;
    samp_d       = samp_q;
    wr_ack_d     = 1'b0;
    rd_valid_d   = 1'b0;
    burst_done_d = 1'b0;
    rd_addr_d    = rd_addr_q;
    rd_data_d    = rd_data_q;
    err_d        = tmo_evt;
    bus_out_d    = 8'h00;

    if (run && !(done_evt || tmo_evt)) cnt_d = cnt_q + CNT_W'(1);
    if ((state_q == S_GAP) && (state_d == S_GAP)) gap_d = gap_q + GAP_W'(1);

    if (wr_req && wr_ready_q) begin
      full_d  = 1'b1;
      waddr_d = wr_addr;
      wdata_d = wr_data;
    end
    // Buffer frees the cycle after the ack, or at the end of GAP after a timeout
    if (wr_ack_q || (abort_q && (state_q == S_GAP) && (state_d == S_IDLE))) begin
      full_d  = 1'b0;
      abort_d = 1'b0;
    end
    if (tmo_evt && (state_q == S_WR_RUN)) abort_d = 1'b1;
    if (done_evt && (state_q == S_WR_RUN)) wr_ack_d = 1'b1;

    if (refresh_tick && (idx_q == '0) && (state_q != S_RD_RUN)) pend_d = 1'b1;
    if ((state_q == S_IDLE) && !full_q && (idx_q == '0) && pend_q) pend_d = 1'b0;

    if ((state_q == S_RD_RUN) && gen_dat_lect) samp_d = rd_bus_in;
    if ((state_q == S_RD_RUN) && (done_evt || tmo_evt)) begin
      rd_valid_d = done_evt;
      if (done_evt) begin
        rd_addr_d = READ_BASE + 8'(idx_q);
        rd_data_d = gen_dat_lect ? rd_bus_in : samp_q;
      end
      if (idx_q == IDX_W'(N_READ - 1)) begin
        idx_d        = '0;
        burst_done_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    // bus_out lags the generator phase flags by one register stage
    case (state_d)
      S_WR_RUN: bus_out_d = (gen_dat && !gen_dir) ? wdata_q : waddr_q;
      S_RD_RUN: bus_out_d = READ_BASE + 8'(idx_q);
      default:  bus_out_d = 8'h00;
    endcase

    wr_ready_d = !full_d;
    en_esc_d   = (state_d == S_WR_RUN);
    en_lect_d  = (state_d == S_RD_RUN);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      gap_q        <= '0;
      idx_q        <= '0;
      full_q       <= 1'b0;
      abort_q      <= 1'b0;
      pend_q       <= 1'b0;
      waddr_q      <= 8'h00;
      wdata_q      <= 8'h00;
      samp_q       <= 8'h00;
      wr_ready_q   <= 1'b1;
      wr_ack_q     <= 1'b0;
      en_esc_q     <= 1'b0;
      en_lect_q    <= 1'b0;
      bus_out_q    <= 8'h00;
      rd_valid_q   <= 1'b0;
      burst_done_q <= 1'b0;
      rd_addr_q    <= 8'h00;
      rd_data_q    <= 8'h00;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      idx_q        <= idx_d;
      full_q       <= full_d;
      abort_q      <= abort_d;
      pend_q       <= pend_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
      samp_q       <= samp_d;
      wr_ready_q   <= wr_ready_d;
      wr_ack_q     <= wr_ack_d;
      en_esc_q     <= en_esc_d;
      en_lect_q    <= en_lect_d;
      bus_out_q    <= bus_out_d;
      rd_valid_q   <= rd_valid_d;
      burst_done_q <= burst_done_d;
      rd_addr_q    <= rd_addr_d;
      rd_data_q    <= rd_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign wr_ack     = wr_ack_q;
  assign en_esc     = en_esc_q;
  assign en_lect    = en_lect_q;
  assign bus_out    = bus_out_q;
  assign rd_valid   = rd_valid_q;
  assign rd_addr    = rd_addr_q;
  assign rd_data    = rd_data_q;
  assign busy       = busy_q;
  assign burst_done = burst_done_q;
  assign err        = err_q;

endmodule

// File: tb/tb_rtc_bus_scheduler.sv
// Bench for rtc_bus_scheduler: generator model, read scoreboard and directed
// scenarios for writes, bursts, preemption, timeout, dropped tick and reset.
module tb_rtc_bus_scheduler;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       refresh_tick, wr_req;
  logic [7:0] wr_addr, wr_data;
  logic       wr_ready, wr_ack;
  logic       gen_dir, gen_dat, gen_dat_lect, gen_done;
  logic       en_esc, en_lect;
  logic [7:0] bus_out, rd_bus_in;
  logic       rd_valid;
  logic [7:0] rd_addr, rd_data;
  logic       busy, burst_done, err;

  rtc_bus_scheduler dut (
    .clk(clk), .reset(reset), .refresh_tick(refresh_tick),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .wr_ack(wr_ack),
    .gen_dir(gen_dir), .gen_dat(gen_dat), .gen_dat_lect(gen_dat_lect),
    .gen_done(gen_done), .en_esc(en_esc), .en_lect(en_lect),
    .bus_out(bus_out), .rd_bus_in(rd_bus_in),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_data(rd_data),
    .busy(busy), .burst_done(burst_done), .err(err)
  );

  always #5 clk = ~clk;

  // Generator model: phase flags from a cycle count while an enable is high
  int gcnt;
  int done_at;
  always @(posedge clk or posedge reset) begin
    if (reset)                gcnt <= 0;
    else if (en_esc || en_lect) gcnt <= gcnt + 1;
    else                      gcnt <= 0;
  end
  assign gen_dir      = (gcnt >= 1) && (gcnt <= 8);
  assign gen_dat      = (gcnt >= 9) && (gcnt <= 20);
  assign gen_dat_lect = en_lect && (gcnt >= 15) && (gcnt <= 18);
  assign gen_done     = (done_at != 0) && ((gcnt == done_at) || (gcnt == done_at + 1));
  assign rd_bus_in    = gen_dat_lect ? 8'('h30 + int'(bus_out) - 'h21) : 8'hFF;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
    logic       last;
  } rd_exp_t;

  rd_exp_t exp_q[$];
  rd_exp_t got_e;
  int  rd_seen, ack_seen, err_seen, esc_cycles, ack_at_rd;
  bit  esc_seen;

  task automatic push_burst();
    rd_exp_t e;
    for (int k = 0; k < 6; k++) begin
      e.a    = 8'('h21 + k);
      e.d    = 8'('h30 + k);
      e.last = (k == 5);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: pops expected reads as rd_valid appears, tallies other events
  always @(negedge clk) begin
    if (!reset) begin
      if (en_esc) begin esc_cycles++; esc_seen = 1'b1; end
      if (wr_ack) begin ack_seen++; ack_at_rd = rd_seen; end
      if (err) err_seen++;
      if (rd_valid) begin
        rd_seen++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_unexpected: got addr 0x%0h data 0x%0h, none expected", rd_addr, rd_data);
        end else begin
          got_e = exp_q.pop_front();
          check("rd_addr", int'(rd_addr), int'(got_e.a));
          check("rd_data", int'(rd_data), int'(got_e.d));
          check("rd_burst_done", int'(burst_done), int'(got_e.last));
        end
      end
    end
  end

  task automatic tick();
    refresh_tick = 1'b1;
    @(negedge clk);
    refresh_tick = 1'b0;
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d);
    wr_req = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_req = 1'b0;
  endtask

  initial begin
    int n;
    refresh_tick = 1'b0; wr_req = 1'b0; wr_addr = 8'h00; wr_data = 8'h00;
    done_at = 25;
    rd_seen = 0; ack_seen = 0; err_seen = 0; esc_cycles = 0; ack_at_rd = 0; esc_seen = 1'b0;
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_wr_ready", int'(wr_ready), 1);
    check("rst_en_esc", int'(en_esc), 0);
    check("rst_en_lect", int'(en_lect), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bus_out", int'(bus_out), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_addr", int'(rd_addr), 0);
    check("rst_err", int'(err), 0);
    reset = 1'b0;
    @(negedge clk);

    // Single write
    write(8'h02, 8'h10);
    check("wr_ready_low", int'(wr_ready), 0);
    n = 0; while (!(en_esc && gen_dir) && n < 200) begin @(negedge clk); n++; end
    check("wr_addr_phase", int'(en_esc && gen_dir), 1);
    check("wr_bus_addr", int'(bus_out), 'h02);
    n = 0; while (gcnt != 12 && n < 200) begin @(negedge clk); n++; end
    check("wr_bus_data", int'(bus_out), 'h10);
    n = 0; while (!wr_ack && n < 200) begin @(negedge clk); n++; end
    check("wr_ack_seen", int'(wr_ack), 1);
    check("wr_gap1_en_esc", int'(en_esc), 0);
    @(negedge clk);
    check("wr_gap2_en_esc", int'(en_esc), 0);
    check("wr_ack_one_cycle", int'(wr_ack), 0);
    check("wr_ready_back", int'(wr_ready), 1);
    repeat (5) @(negedge clk);
    check("wr_ack_count", ack_seen, 1);

    // Read burst
    rd_seen = 0; esc_seen = 1'b0;
    push_burst();
    tick();
    n = 0; while (!(rd_seen == 6 && !busy) && n < 2000) begin @(negedge clk); n++; end
    check("burst_reads", rd_seen, 6);
    check("burst_no_esc", int'(esc_seen), 0);
    check("burst_queue_empty", exp_q.size(), 0);

    // Write preempts the burst between reads 3 and 4
    rd_seen = 0; ack_seen = 0;
    push_burst();
    tick();
    n = 0; while (!(rd_seen == 2 && en_lect) && n < 2000) begin @(negedge clk); n++; end
    check("pre_third_read", int'(rd_seen == 2 && en_lect), 1);
    write(8'h05, 8'h55);
    n = 0; while (!(rd_seen == 6 && !busy) && n < 3000) begin @(negedge clk); n++; end
    check("pre_reads", rd_seen, 6);
    check("pre_ack_count", ack_seen, 1);
    check("pre_ack_after_read3", ack_at_rd, 3);

    // Write timeout
    done_at = 0; esc_cycles = 0; err_seen = 0; ack_seen = 0;
    write(8'h03, 8'h44);
    n = 0; while (!err && n < 400) begin @(negedge clk); n++; end
    check("tmo_err", int'(err), 1);
    check("tmo_run_cycles", esc_cycles, 100);
    check("tmo_en_low", int'(en_esc), 0);
    check("tmo_ready_g1", int'(wr_ready), 0);
    @(negedge clk);
    check("tmo_ready_g2", int'(wr_ready), 0);
    check("tmo_err_one_cycle", int'(err), 0);
    @(negedge clk);
    check("tmo_ready_release", int'(wr_ready), 1);
    check("tmo_no_ack", ack_seen, 0);
    done_at = 25;
    write(8'h04, 8'h66);
    n = 0; while (!wr_ack && n < 200) begin @(negedge clk); n++; end
    check("tmo_next_ack", int'(wr_ack), 1);
    check("tmo_err_count", err_seen, 1);
    repeat (5) @(negedge clk);

    // Second tick while the first burst is starting is dropped
    rd_seen = 0;
    push_burst();
    tick();
    repeat (4) @(negedge clk);
    tick();
    n = 0; while (!(rd_seen == 6 && !busy) && n < 2000) begin @(negedge clk); n++; end
    repeat (200) @(negedge clk);
    check("drop_reads", rd_seen, 6);
    check("drop_idle", int'(busy), 0);
    check("drop_queue_empty", exp_q.size(), 0);

    // Reset in the middle of the read at index 3
    rd_seen = 0;
    push_burst();
    tick();
    n = 0; while (!(rd_seen == 3 && en_lect) && n < 2000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    check("mid_in_read", int'(en_lect), 1);
    #2 reset = 1'b1;
    #1;
    check("mid_en_lect_drop", int'(en_lect), 0);
    check("mid_busy_drop", int'(busy), 0);
    check("mid_en_esc", int'(en_esc), 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    repeat (50) @(negedge clk);
    check("post_rst_busy", int'(busy), 0);
    check("post_rst_en_lect", int'(en_lect), 0);
    check("post_rst_no_reads", rd_seen, 3);
    rd_seen = 0;
    push_burst();
    tick();
    n = 0; while (!(rd_seen == 6 && !busy) && n < 2000) begin @(negedge clk); n++; end
    check("post_rst_burst", rd_seen, 6);
    check("post_rst_queue", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rtc_bus_scheduler.md
Name: rtc_bus_scheduler

Overview:
- Sequences the RTC bus timing generator; the generator does not arbitrate.
- Serves two requesters:
  - a one-entry buffered user write port (edits of time, date and config registers);
  - a periodic read burst that refreshes the RTC time registers (seconds through year).
- Drives the generator's write and read enables and the 8-bit address/data value placed on the bus.
- Captures read data and returns it to the display/register side.

Parameters:
- READ_BASE, 8'h21, address of the first register in the read burst.
- N_READ, 6, number of consecutive registers read per burst (READ_BASE .. READ_BASE+N_READ-1).
- GAP, 2, idle cycles with both enables low between transactions, so the generator counter clears.
- TIMEOUT, 100, maximum cycles a transaction may wait for the generator's done flag.

Ports:
- clk  in  1  system clock
- reset  in  1  reset, asynchronous, active-high
- refresh_tick  in  1  one-cycle pulse requesting a read burst
- wr_req  in  1  write request valid
- wr_addr  in  8  RTC register address for the write
- wr_data  in  8  data for the write
- wr_ready  out  1  high when the write buffer is empty
- wr_ack  out  1  one-cycle pulse when the buffered write completes
- gen_dir  in  1  generator address-phase flag
- gen_dat  in  1  generator data-phase flag
- gen_dat_lect  in  1  generator read-sample flag
- gen_done  in  1  generator end-of-transaction flag (2-cycle pulse)
- en_esc  out  1  generator write enable
- en_lect  out  1  generator read enable
- bus_out  out  8  value for the external tristate bus driver
- rd_bus_in  in  8  bus value sampled during reads
- rd_valid  out  1  one-cycle pulse, read result valid
- rd_addr  out  8  address of the current read result
- rd_data  out  8  data of the current read result
- busy  out  1  high when not in IDLE
- burst_done  out  1  one-cycle pulse after the last burst read
- err  out  1  one-cycle pulse on transaction timeout

Behaviour:
- Reset values:
  - All outputs 0, except wr_ready=1.
  - State IDLE; write buffer empty; burst pending flag clear; burst index 0.
- Reset is asynchronous and may hit mid-transaction: enables drop immediately and nothing resumes after release.
- Write buffer:
  - A write is accepted in a cycle where wr_req && wr_ready; addr/data are latched and wr_ready=0 from the next cycle.
  - wr_ready returns to 1 in the cycle after wr_ack.
- Burst request:
  - refresh_tick sets the pending flag; it is a single flag, not a counter.
  - A tick arriving while pending is already set, or while a burst is in progress, is dropped.
  - The flag clears when burst index 0 starts.
- States: IDLE, WR_RUN, RD_RUN, GAP.
  - IDLE: if the write buffer is full -> WR_RUN. Else if a burst is active (index>0) or pending -> RD_RUN. Write has priority.
  - WR_RUN: en_esc=1, en_lect=0.
  - RD_RUN: en_lect=1, en_esc=0. Address = READ_BASE+index.
  - In either RUN state, on the first cycle of gen_done -> GAP. The enable is low from the next cycle.
  - GAP: both enables low for exactly GAP cycles -> IDLE.
  - Arbitration happens only in IDLE, so a write preempts a burst between reads, never inside one. The burst resumes at the saved index.
- bus_out:
  - In WR_RUN: wr_data while gen_dat=1, otherwise wr_addr.
  - In RD_RUN: the read address.
  - 8'h00 in IDLE and GAP.
- Read capture:
  - rd_bus_in is registered on every cycle of RD_RUN with gen_dat_lect=1; the last sample wins.
  - On the cycle that leaves RD_RUN via gen_done: rd_valid=1, rd_addr and rd_data updated and then held. The index increments.
  - When the index reaches N_READ: the index wraps to 0 and burst_done pulses with rd_valid.
- Write completion: wr_ack pulses on the cycle leaving WR_RUN via gen_done.
- Timeout:
  - A cycle counter runs in the RUN states. If it reaches TIMEOUT without gen_done: err pulses and -> GAP.
  - On a write timeout: no wr_ack, and the buffer is released (wr_ready=1 after GAP).
  - On a read timeout: rd_valid is not pulsed, the index still advances, and burst_done still pulses at the end.
- Simultaneous events:
  - gen_done and timeout in the same cycle: treated as done.
  - refresh_tick and wr_req in the same cycle: both are registered; the write is served first.

Test Plan:
- Write: wr_req with addr=8'h02, data=8'h10, generator model done at cycle 25 -> en_esc high until done, bus_out 8'h02 then 8'h10 during gen_dat, wr_ack once, en_esc low for 2 cycles, wr_ready=1.
- Read burst: refresh_tick, model returns 8'h30+k for address 8'h21+k -> 6 rd_valid pulses at addresses 8'h21..8'h26 with data 8'h30..8'h35, burst_done with the 6th, en_esc never high.
- Preemption: write request during the 3rd burst read -> the 3rd read completes, the write runs next, then reads resume at 8'h24; total rd_valid=6.
- Timeout: model never asserts done in WR_RUN -> err pulses at cycle 100 of RUN, no wr_ack, wr_ready=1 after GAP, next request served normally.
- Dropped tick: two refresh_ticks 5 cycles apart while idle -> exactly one burst of 6 reads.
- Mid-operation reset: reset during RD_RUN at index 3 -> enables and busy drop immediately; after release the state is IDLE with no activity until a new request.
